resync_wr_sched: RTL and testbench

- Write-side scheduler that shares one resync_data clock-crossing FIFO among NUM_CHN requesters, all in the FIFO write clock domain.
- Grants channels round-robin in bounded bursts and tags each word with its channel number.
- Prevents FIFO overrun with a credit counter replenished by read tokens, since the FIFO itself has no overrun check.
- Sequences FIFO re-initialisation through the FIFO's srst.

---
 rtl/resync_wr_sched_if.sv | 18 +
 rtl/resync_wr_sched.sv | 149 ++++++++++++++
 tb/tb_resync_wr_sched.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/resync_wr_sched_if.sv
// Requester and FIFO write-port bundle for resync_wr_sched.
// The scheduler uses the slave view. Requesters and the FIFO use the master view.
interface resync_wr_sched_if #(
  parameter int NUM_CHN    = 4,
  parameter int CHN_BITS   = 2,
  parameter int DATA_WIDTH = 16
);
  logic [NUM_CHN-1:0]             req;
  logic [NUM_CHN*DATA_WIDTH-1:0]  din;
  logic [NUM_CHN-1:0]             ack;
  logic                           rd_token;
  logic                           fifo_srst;
  logic                           fifo_we;
  logic [CHN_BITS+DATA_WIDTH-1:0] fifo_din;

  modport master (output req, din, rd_token, input ack, fifo_srst, fifo_we, fifo_din);
  modport slave  (input req, din, rd_token, output ack, fifo_srst, fifo_we, fifo_din);
endinterface

// File: rtl/resync_wr_sched.sv
// Round-robin burst scheduler feeding a shared clock-crossing FIFO, tagged {chn, data}; FIFO write 1 cycle after ack.
// Backpressure: ack stalls while credits are 0; credits are returned by rd_token; init re-runs the FIFO srst sequence.
module resync_wr_sched #(
  parameter int NUM_CHN       = 4,
  parameter int CHN_BITS      = 2,
  parameter int DATA_WIDTH    = 16,
  parameter int DATA_DEPTH    = 4,
  parameter int CREDIT_MARGIN = 2,
  parameter int BURST_LEN     = 8,
  parameter int SRST_CYCLES   = 4
) (
  input  logic                  mclk,
  input  logic                  arst_n,
  input  logic                  init,
  resync_wr_sched_if.slave      bus,
  output logic [DATA_DEPTH:0]   credits,
  output logic [CHN_BITS-1:0]   active_chn,
  output logic                  busy,
  output logic                  ovf_err
);
  localparam int                  CMAX_I     = 2**DATA_DEPTH - CREDIT_MARGIN;
  localparam logic [DATA_DEPTH:0] CMAX       = CMAX_I[DATA_DEPTH:0];
  localparam logic [7:0]          SRST_LAST  = 8'(SRST_CYCLES - 1);
  localparam logic [7:0]          BURST_LAST = 8'(BURST_LEN - 1);
  localparam logic [CHN_BITS-1:0] LAST_CHN   = CHN_BITS'(NUM_CHN - 1);

  typedef enum logic [1:0] {ST_RESET, ST_IDLE, ST_BURST} state_t;

  state_t              state, state_nxt;
  logic [7:0]          rst_cnt, rst_cnt_nxt;
  logic [7:0]          burst_cnt, burst_cnt_nxt;
  logic [CHN_BITS-1:0] rr_ptr, rr_ptr_nxt, active_nxt;
  logic [CHN_BITS-1:0] pick_chn, scan_idx, next_chn;
  logic                pick_vld, ack_fire, load_cred;
  logic [DATA_WIDTH-1:0] sel_dat;

  // First requester at or above the rr pointer, wrapping around.
  always_comb begin
    pick_vld = 1'b0;
    pick_chn = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_CHN; i++) begin
      scan_idx = CHN_BITS'((int'(rr_ptr) + i) % NUM_CHN);
      if (!pick_vld && bus.req[scan_idx]) begin
        pick_vld = 1'b1;
        pick_chn = scan_idx;
      end
    end
  end

  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < NUM_CHN; i++) begin
      if (active_chn == CHN_BITS'(i)) sel_dat = bus.din[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign next_chn = (active_chn == LAST_CHN) ? '0 : active_chn + 1'b1;
  assign ack_fire = (state == ST_BURST) && bus.req[active_chn] && (credits != '0) && !init;
  assign bus.ack  = ack_fire ? (NUM_CHN'(1) << active_chn) : '0;

  always_comb begin
    state_nxt     = state;
    rst_cnt_nxt   = rst_cnt;
    burst_cnt_nxt = burst_cnt;
    rr_ptr_nxt    = rr_ptr;
    active_nxt    = active_chn;
    load_cred     = 1'b0;
    case (state)
      ST_RESET: begin
        rst_cnt_nxt = rst_cnt + 8'd1;
        if (rst_cnt == SRST_LAST) begin
          state_nxt   = ST_IDLE;
          rst_cnt_nxt = '0;
          load_cred   = 1'b1;
        end
      end
      ST_IDLE: begin
        if (pick_vld) begin
          state_nxt     = ST_BURST;
          active_nxt    = pick_chn;
          burst_cnt_nxt = '0;
        end
      end
      ST_BURST: begin
        if (!bus.req[active_chn] || (ack_fire && burst_cnt == BURST_LAST)) begin
          state_nxt  = ST_IDLE;
          rr_ptr_nxt = next_chn;
        end else if (ack_fire) begin
          burst_cnt_nxt = burst_cnt + 8'd1;
        end
      end
      default: state_nxt = ST_RESET;
    endcase
    // init aborts everything but leaves the fairness pointer and grant alone.
    if (init) begin
      state_nxt   = ST_RESET;
      rst_cnt_nxt = '0;
      load_cred   = 1'b0;
      rr_ptr_nxt  = rr_ptr;
      active_nxt  = active_chn;
    end
  end

  always_ff @(posedge mclk or negedge arst_n) begin
    if (!arst_n) begin
      state         <= ST_RESET;
      rst_cnt       <= '0;
      burst_cnt     <= '0;
      rr_ptr        <= '0;
      active_chn    <= '0;
      bus.fifo_srst <= 1'b1;
      busy          <= 1'b1;
    end else begin
      state         <= state_nxt;
      rst_cnt       <= rst_cnt_nxt;
      burst_cnt     <= burst_cnt_nxt;
      rr_ptr        <= rr_ptr_nxt;
      active_chn    <= active_nxt;
      bus.fifo_srst <= (state_nxt == ST_RESET);
      busy          <= (state_nxt != ST_IDLE);
    end
  end

  always_ff @(posedge mclk or negedge arst_n) begin
    if (!arst_n) begin
      bus.fifo_we  <= 1'b0;
      bus.fifo_din <= '0;
      credits      <= '0;
      ovf_err      <= 1'b0;
    end else begin
      bus.fifo_we <= ack_fire;
      if (ack_fire) bus.fifo_din <= {active_chn, sel_dat};
      if (load_cred) begin
        credits <= CMAX;
        ovf_err <= 1'b0;
      end else if (state != ST_RESET) begin
        case ({ack_fire, bus.rd_token})
          2'b10:   credits <= credits - 1'b1;
          2'b01: begin
            if (credits == CMAX) ovf_err <= 1'b1;
            else                 credits <= credits + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_resync_wr_sched.sv
// Bench for resync_wr_sched: directed scenarios plus random traffic, checked every cycle
// against a countdown/grant-index model of the scheduling rules.
module tb_resync_wr_sched;
  localparam int N = 4, CB = 2, DW = 16, DD = 4, MARGIN = 2, BL = 8, SRST = 4;
  localparam int CMAX = 2**DD - MARGIN;

  logic          mclk = 1'b0;
  logic          arst_n = 1'b0;
  logic          init = 1'b0;
  logic [DD:0]   credits;
  logic [CB-1:0] active_chn;
  logic          busy, ovf_err;

  resync_wr_sched_if #(.NUM_CHN(N), .CHN_BITS(CB), .DATA_WIDTH(DW)) bus ();

  resync_wr_sched #(
    .NUM_CHN(N), .CHN_BITS(CB), .DATA_WIDTH(DW), .DATA_DEPTH(DD),
    .CREDIT_MARGIN(MARGIN), .BURST_LEN(BL), .SRST_CYCLES(SRST)
  ) dut (
    .mclk(mclk), .arst_n(arst_n), .init(init), .bus(bus.slave),
    .credits(credits), .active_chn(active_chn), .busy(busy), .ovf_err(ovf_err)
  );

  always #5 mclk = ~mclk;

  // model state
  int   m_srst_left, m_grant, m_words, m_rr, m_active, m_cred;
  bit   m_ovf, m_we;
  logic [CB+DW-1:0] m_din;
  // stimulus state
  int   words_left [N];
  bit   req_now [N];
  logic [DW-1:0] din_a [N];
  int   tok_mode, tok_pulse;
  bit   init_pend, rel_pend, tok;
  int   checks, errors, dut_acks;
  int   bl_q [$];
  int   bc_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_srst_left = SRST; m_grant = -1; m_words = 0; m_rr = 0; m_active = 0;
    m_cred = 0; m_ovf = 0; m_we = 0; m_din = '0;
  endtask

  function automatic logic [N-1:0] exp_ack();
    logic [N-1:0] a = '0;
    if (m_srst_left == 0 && m_grant >= 0 && req_now[m_grant] && m_cred > 0 && !init) a[m_grant] = 1'b1;
    return a;
  endfunction

  task automatic model_step(input logic [N-1:0] ea);
    bit a = |ea;
    int g = m_grant;
    m_we = a;
    if (a) begin
      m_din = {g[CB-1:0], din_a[g]};
      words_left[g]--;
    end
    if (m_srst_left > 0) begin
      if (m_srst_left == 1 && !init) begin m_cred = CMAX; m_ovf = 0; end
    end else if (a && !tok) begin
      m_cred--;
    end else if (tok && !a) begin
      if (m_cred == CMAX) m_ovf = 1; else m_cred++;
    end
    if (init) begin
      m_srst_left = SRST; m_grant = -1;
    end else if (m_srst_left > 0) begin
      m_srst_left--;
    end else if (m_grant < 0) begin
      for (int k = 0; k < N; k++) begin
        int c = (m_rr + k) % N;
        if (m_grant < 0 && req_now[c]) begin m_grant = c; m_active = c; m_words = 0; end
      end
    end else begin
      if (a) m_words++;
      if (!req_now[g] || m_words == BL) begin
        bl_q.push_back(m_words); bc_q.push_back(g);
        m_rr = (g + 1) % N; m_grant = -1;
      end
    end
  endtask

  task automatic cycle();
    logic [N-1:0] ea;
    @(posedge mclk); #1;
    if (rel_pend) begin arst_n = 1'b1; rel_pend = 0; end
    init = init_pend; init_pend = 0;
    tok = (tok_pulse > 0) || tok_mode == 1 || (tok_mode == 2 && $urandom_range(0, 1) == 1);
    if (tok_pulse > 0) tok_pulse--;
    bus.rd_token = tok;
    for (int i = 0; i < N; i++) begin
      req_now[i] = words_left[i] > 0;
      bus.req[i] = req_now[i];
      din_a[i] = DW'($urandom);
      bus.din[i*DW +: DW] = din_a[i];
    end
    @(negedge mclk);
    if (arst_n) begin
      ea = exp_ack();
      chk("ack", 64'(bus.ack), 64'(ea));
      chk("fifo_srst", 64'(bus.fifo_srst), 64'(m_srst_left > 0));
      chk("fifo_we", 64'(bus.fifo_we), 64'(m_we));
      chk("fifo_din", 64'(bus.fifo_din), 64'(m_din));
      chk("credits", 64'(credits), 64'(m_cred));
      chk("active_chn", 64'(active_chn), 64'(m_active));
      chk("busy", 64'(busy), 64'((m_srst_left > 0) || (m_grant >= 0)));
      chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
      model_step(ea);
    end
    if (bus.ack != '0) dut_acks++;
  endtask

  task automatic count_srst(input string name);
    int n = 0;
    bit done = 0;
    for (int c = 0; c < 30 && !done; c++) begin
      cycle();
      if (bus.fifo_srst) n++;
      else if (n > 0) done = 1;
    end
    chk({name, "_srst_len"}, 64'(n), 64'd4);
    chk({name, "_credits"}, 64'(credits), 64'd14);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_ovf"}, 64'(ovf_err), 64'd0);
  endtask

  initial begin
    int a0, n, c0;
    bit found;
    logic [DW-1:0] d3;
    checks = 0; errors = 0; dut_acks = 0;
    tok_mode = 0; tok_pulse = 0; init_pend = 0; rel_pend = 0; tok = 0;
    for (int i = 0; i < N; i++) words_left[i] = 0;
    bus.req = '0; bus.din = '0; bus.rd_token = 1'b0;
    model_reset();

    repeat (3) @(posedge mclk);
    @(negedge mclk);
    chk("rst_srst", 64'(bus.fifo_srst), 64'd1);
    chk("rst_we", 64'(bus.fifo_we), 64'd0);
    chk("rst_din", 64'(bus.fifo_din), 64'd0);
    chk("rst_credits", 64'(credits), 64'd0);
    chk("rst_active", 64'(active_chn), 64'd0);
    chk("rst_ovf", 64'(ovf_err), 64'd0);
    chk("rst_ack", 64'(bus.ack), 64'd0);

    rel_pend = 1;
    count_srst("boot");

    // three channels contend, rr starts at 0
    tok_mode = 1;
    words_left[0] = 16; words_left[1] = 16; words_left[3] = 16;
    bl_q.delete(); bc_q.delete();
    repeat (80) cycle();
    chk("rr_nbursts", 64'(bc_q.size() >= 4), 64'd1);
    if (bc_q.size() >= 4) begin
      chk("rr_order0", 64'(bc_q[0]), 64'd0);
      chk("rr_order1", 64'(bc_q[1]), 64'd1);
      chk("rr_order2", 64'(bc_q[2]), 64'd3);
      chk("rr_order3", 64'(bc_q[3]), 64'd0);
      chk("rr_len0", 64'(bl_q[0]), 64'd8);
      chk("rr_len3", 64'(bl_q[3]), 64'd8);
    end

    // 20 words on channel 2
    words_left[2] = 20;
    bl_q.delete(); bc_q.delete();
    repeat (40) cycle();
    chk("ch2_nbursts", 64'(bl_q.size()), 64'd3);
    if (bl_q.size() == 3) begin
      chk("ch2_len0", 64'(bl_q[0]), 64'd8);
      chk("ch2_len1", 64'(bl_q[1]), 64'd8);
      chk("ch2_len2", 64'(bl_q[2]), 64'd4);
      chk("ch2_tag", 64'(bc_q[2]), 64'd2);
    end

    // credit exhaustion without tokens
    tok_mode = 0;
    words_left[1] = 30;
    a0 = dut_acks;
    repeat (40) cycle();
    chk("nocred_acks", 64'(dut_acks - a0), 64'd14);
    chk("nocred_credits", 64'(credits), 64'd0);
    chk("nocred_busy", 64'(busy), 64'd1);
    chk("nocred_ack0", 64'(bus.ack), 64'd0);
    tok_pulse = 1;
    a0 = dut_acks;
    repeat (10) cycle();
    chk("onetok_acks", 64'(dut_acks - a0), 64'd1);
    words_left[1] = 0;
    repeat (3) cycle();

    // token refill, token coincident with ack, overflow
    tok_pulse = 5;
    repeat (8) cycle();
    chk("refill5", 64'(credits), 64'd5);
    words_left[3] = 3; tok_mode = 1;
    found = 0; c0 = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      cycle();
      if (bus.ack != '0 && bus.rd_token) begin c0 = int'(credits); found = 1; end
    end
    chk("acktok_seen", 64'(found), 64'd1);
    cycle();
    chk("acktok_hold", 64'(credits), 64'(c0));
    repeat (25) cycle();
    chk("ovf_credits", 64'(credits), 64'd14);
    chk("ovf_set", 64'(ovf_err), 64'd1);

    // init at the third word of a burst
    words_left[0] = 20;
    n = 0; found = 0; d3 = '0;
    for (int c = 0; c < 40 && !found; c++) begin
      cycle();
      if (bus.ack[0]) begin
        n++;
        if (n == 3) begin d3 = din_a[0]; found = 1; end
      end
    end
    chk("init_word3_seen", 64'(found), 64'd1);
    init_pend = 1;
    cycle();
    chk("init_ack", 64'(bus.ack), 64'd0);
    chk("init_we", 64'(bus.fifo_we), 64'd1);
    chk("init_din", 64'(bus.fifo_din), 64'({2'd0, d3}));
    count_srst("init");
    words_left[1] = 5;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      cycle();
      if (bus.ack != '0) begin
        found = 1;
        chk("init_rr_kept", 64'(bus.ack), 64'h1);
      end
    end
    chk("init_regrant_seen", 64'(found), 64'd1);

    // random traffic
    tok_mode = 2;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        int ch = int'($urandom_range(0, N - 1));
        words_left[ch] += int'($urandom_range(1, 12));
      end
      if ($urandom_range(0, 199) == 0) init_pend = 1;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
